// File: rtl/cp0_timer.sv
// CP0 timer: Count register advanced by a programmable prescaler, a Compare
// register, and a registered level interrupt raised when Count ticks onto
// Compare. Shares the CP0 register-file access interface.
//
// Ports:
//   clk        core clock
//   resetn     synchronous active-low reset
//   cp0_en     CP0 access valid this cycle
//   cp0_wen    write strobe, qualified by cp0_en
//   cp0_addr   CP0 register number
//   cp0_wdata  write data
//   cp0_rdata  combinational read data (0 unless a mapped read)
//   count_stop freezes Count and the prescaler while high
//   timer_int  timer interrupt pending (feeds Cause.IP7)
module cp0_timer #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned TICK_DIV     = 2,
  parameter logic [4:0]  ADDR_COUNT   = 5'd9,
  parameter logic [4:0]  ADDR_COMPARE = 5'd11
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cp0_en,
  input  logic              cp0_wen,
  input  logic [4:0]        cp0_addr,
  input  logic [DATA_W-1:0] cp0_wdata,
  output logic [DATA_W-1:0] cp0_rdata,
  input  logic              count_stop,
  output logic              timer_int
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PreMax = PW'(TICK_DIV - 1);

  logic [PW-1:0]     pre_q, pre_d;
  logic [DATA_W-1:0] count_q, count_d;
  logic [DATA_W-1:0] compare_q, compare_d;
  logic              int_q, int_d;

  logic              tick;
  logic              wr_count, wr_compare;
  logic              rd_count, rd_compare;
  logic [DATA_W-1:0] count_inc;

  assign tick       = ~count_stop & (pre_q == PreMax);
  assign wr_count   = cp0_en & cp0_wen & (cp0_addr == ADDR_COUNT);
  assign wr_compare = cp0_en & cp0_wen & (cp0_addr == ADDR_COMPARE);
  assign rd_count   = cp0_en & ~cp0_wen & (cp0_addr == ADDR_COUNT);
  assign rd_compare = cp0_en & ~cp0_wen & (cp0_addr == ADDR_COMPARE);
  assign count_inc  = count_q + DATA_W'(1);

  always_comb begin
    // Prescaler runs independently of Count writes; only count_stop freezes it.
    pre_d = pre_q;
    if (!count_stop) begin
      pre_d = (pre_q == PreMax) ? '0 : pre_q + PW'(1);
    end

    count_d = count_q;
    if (wr_count) begin
      count_d = cp0_wdata;
    end else if (tick) begin
      count_d = count_inc;
    end

    compare_d = compare_q;
    if (wr_compare) begin
      compare_d = cp0_wdata;
    end

    // Only a tick can reach Compare; writing Count onto it never fires.
    int_d = int_q;
    if (wr_compare) begin
      int_d = 1'b0;
    end else if (tick && !wr_count && (count_inc == compare_q)) begin
      int_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pre_q     <= '0;
      count_q   <= '0;
      compare_q <= '1;
      int_q     <= 1'b0;
    end else begin
      pre_q     <= pre_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      int_q     <= int_d;
    end
  end

  // Reads see pre-update register values.
  always_comb begin
    cp0_rdata = '0;
    if (rd_count) begin
      cp0_rdata = count_q;
    end else if (rd_compare) begin
      cp0_rdata = compare_q;
    end
  end

  assign timer_int = int_q;

endmodule

// File: tb/tb_cp0_timer.sv
// Randomised and directed bench for cp0_timer. Two instances (TICK_DIV 2 and
// 4) share the stimulus and are compared against a cycle-level reference
// model built from the register rules.
module tb_cp0_timer;

  logic        clk = 1'b0;
  logic        resetn, cp0_en, cp0_wen, count_stop;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic [31:0] rdata2, rdata4;
  logic        int2, int4;

  always #5 clk = ~clk;

  cp0_timer #(.DATA_W(32), .TICK_DIV(2)) dut2 (
    .clk       (clk),
    .resetn    (resetn),
    .cp0_en    (cp0_en),
    .cp0_wen   (cp0_wen),
    .cp0_addr  (cp0_addr),
    .cp0_wdata (cp0_wdata),
    .cp0_rdata (rdata2),
    .count_stop(count_stop),
    .timer_int (int2)
  );

  cp0_timer #(.DATA_W(32), .TICK_DIV(4)) dut4 (
    .clk       (clk),
    .resetn    (resetn),
    .cp0_en    (cp0_en),
    .cp0_wen   (cp0_wen),
    .cp0_addr  (cp0_addr),
    .cp0_wdata (cp0_wdata),
    .cp0_rdata (rdata4),
    .count_stop(count_stop),
    .timer_int (int4)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: Count/Compare/int per instance, plus the number of
  // non-stopped cycles since reset; a tick happens on every div-th such cycle.
  logic [31:0] m_cnt [2];
  logic [31:0] m_cmp [2];
  logic        m_int [2];
  int unsigned m_act [2];
  int unsigned m_div [2] = '{2, 4};

  function automatic logic [31:0] exp_rdata(input int k);
    if (!cp0_en || cp0_wen) return 32'h0;
    if (cp0_addr == 5'd9)   return m_cnt[k];
    if (cp0_addr == 5'd11)  return m_cmp[k];
    return 32'h0;
  endfunction

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      if (!resetn) begin
        m_cnt[k] = 32'h0;
        m_cmp[k] = 32'hFFFF_FFFF;
        m_int[k] = 1'b0;
        m_act[k] = 0;
      end else begin
        logic tk, wc, wm;
        tk = !count_stop && ((m_act[k] % m_div[k]) == m_div[k] - 1);
        wc = cp0_en && cp0_wen && cp0_addr == 5'd9;
        wm = cp0_en && cp0_wen && cp0_addr == 5'd11;
        if (wm) m_int[k] = 1'b0;
        else if (tk && !wc && (m_cnt[k] + 32'd1) == m_cmp[k]) m_int[k] = 1'b1;
        if (wc) m_cnt[k] = cp0_wdata;
        else if (tk) m_cnt[k] = m_cnt[k] + 32'd1;
        if (wm) m_cmp[k] = cp0_wdata;
        if (!count_stop) m_act[k]++;
      end
    end
  endtask

  // Apply one cycle of inputs, compare outputs mid-cycle, then advance model.
  task automatic drive(input logic rn, input logic en, input logic wen, input logic stop,
                       input logic [4:0] a, input logic [31:0] d);
    resetn = rn; cp0_en = en; cp0_wen = wen; count_stop = stop;
    cp0_addr = a; cp0_wdata = d;
    #1;
    check("rdata_div2", rdata2, exp_rdata(0));
    check("rdata_div4", rdata4, exp_rdata(1));
    check("int_div2", {31'h0, int2}, {31'h0, m_int[0]});
    check("int_div4", {31'h0, int4}, {31'h0, m_int[1]});
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic run_reads(input int n, input logic [4:0] a);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, a, $urandom);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    drive(1'b1, 1'b1, 1'b1, 1'b0, a, d);
  endtask

  initial begin
    @(posedge clk); #1;
    // Reset and fixed reset-value checks.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    resetn = 1'b1; cp0_en = 1'b1; cp0_wen = 1'b0; cp0_addr = 5'd11; #1;
    check("reset_compare", rdata2, 32'hFFFF_FFFF);
    cp0_addr = 5'd9; #1;
    check("reset_count", rdata2, 32'h0);
    check("reset_int", {31'h0, int2}, 32'h0);

    // Free run: 10 edges -> Count 5 at div 2, 2 at div 4.
    run_reads(10, 5'd9);
    check("freerun_div2", rdata2, 32'd5);
    check("freerun_div4", rdata4, 32'd2);

    // Compare match, persistence, clear by Compare write.
    wr(5'd9, 32'd0);
    wr(5'd11, 32'd3);
    run_reads(14, 5'd9);
    check("match_held", {31'h0, int2}, 32'h1);
    wr(5'd11, 32'd100);
    run_reads(2, 5'd11);

    // Wrap onto Compare=0.
    wr(5'd11, 32'd0);
    wr(5'd9, 32'hFFFF_FFFE);
    run_reads(10, 5'd9);
    check("wrap_int", {31'h0, int4}, 32'h1);

    // Reset mid-run while int is set.
    drive(1'b0, 1'b1, 1'b1, 1'b0, 5'd9, 32'd123);
    check("midreset_int", {31'h0, int2}, 32'h0);
    run_reads(2, 5'd11);

    // Count written onto Compare: no interrupt.
    wr(5'd11, 32'd7);
    wr(5'd9, 32'd7);
    run_reads(2, 5'd9);

    // Back-to-back Count writes of 50 catch tick-vs-write priority on every phase.
    for (int i = 0; i < 4; i++) wr(5'd9, 32'd50);
    run_reads(2, 5'd9);

    // count_stop at Count=20.
    wr(5'd9, 32'd20);
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b1, 1'b0, 1'b1, 5'd9, 32'h0);
    run_reads(9, 5'd9);

    // Zero-read cases.
    drive(1'b1, 1'b1, 1'b1, 1'b0, 5'd12, 32'hDEAD_BEEF);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 5'd12, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd9, 32'h0);

    // Random phase with values kept near Count so matches actually occur.
    for (int i = 0; i < 4000; i++) begin
      logic        rn, en, wen, stop;
      logic [4:0]  a;
      logic [31:0] d;
      rn   = ($urandom_range(0, 199) != 0);
      en   = ($urandom_range(0, 3) != 0);
      wen  = ($urandom_range(0, 3) == 0);
      stop = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 3))
        0: a = 5'd9;
        1: a = 5'd11;
        2: a = 5'd12;
        default: a = 5'($urandom);
      endcase
      case ($urandom_range(0, 3))
        0: d = 32'($urandom_range(0, 30));
        1: d = m_cnt[$urandom_range(0, 1)] + 32'($urandom_range(0, 3));
        2: d = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
        default: d = $urandom;
      endcase
      drive(rn, en, wen, stop, a, d);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
